// File: rtl/gr02_pkg.sv
// Shared constants and types for the sample averaging block.
package gr02_pkg;

  localparam int CODE_W       = 8;
  localparam int AVG_LOG2_MAX = 6;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/edge_det.sv
// Registered falling-edge detector: fall_q pulses for one cycle, one cycle
// after the cycle in which sig_in is seen low following a high.
module edge_det (
  input  logic clk,
  input  logic n_rst,
  input  logic sig_in,
  output logic fall_q
);

  logic sig_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      sig_q  <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sig_q  <= sig_in;
      fall_q <= sig_q & ~sig_in;
    end
  end

endmodule

// File: rtl/sample_avg.sv
// Averages 2^AVG_LOG2 trigger-qualified codes and presents the truncated mean
// on a valid/ready output with a sticky overrun flag.
module sample_avg
  import gr02_pkg::*;
#(
  parameter int AVG_LOG2 = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                trig_in,
  input  logic [CODE_W-1:0]   code_in,
  input  logic                avg_ready,
  output logic [CODE_W-1:0]   avg_out,
  output logic                avg_valid,
  output logic                overrun,
  output logic [AVG_LOG2:0]   sample_cnt
);

  localparam int                ACC_W   = CODE_W + AVG_LOG2;
  localparam logic [AVG_LOG2:0] CNT_ONE = (AVG_LOG2 + 1)'(1);
  localparam logic [AVG_LOG2:0] WIN     = (AVG_LOG2 + 1)'(1 << AVG_LOG2);

  if (AVG_LOG2 < 0 || AVG_LOG2 > AVG_LOG2_MAX) begin : g_bad_param
    $error("sample_avg: AVG_LOG2 out of range");
  end

  logic                sample_en;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_sum;
  logic [AVG_LOG2:0]   cnt_next;
  logic                done;
  out_state_t          state_q;
  out_state_t          state_d;
  logic                set_ovr;

  edge_det u_edge_det (
    .clk    (clk),
    .n_rst  (n_rst),
    .sig_in (trig_in),
    .fall_q (sample_en)
  );

  // The sum includes the sample being taken, so the window closes on it.
  assign acc_sum  = acc + ACC_W'(code_in);
  assign cnt_next = sample_cnt + CNT_ONE;
  assign done     = sample_en && (cnt_next == WIN);

  // NOTE: the reset clears every register here, including the accumulator, so a
  // partial window never leaks into the first result after reset.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      acc        <= '0;
      sample_cnt <= '0;
    end else if (done) begin
      acc        <= '0;
      sample_cnt <= '0;
    end else if (sample_en) begin
      acc        <= acc_sum;
      sample_cnt <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      avg_out <= '0;
      overrun <= 1'b0;
    end else begin
      if (done) begin
        avg_out <= acc_sum[ACC_W-1:AVG_LOG2];
      end
      if (set_ovr) begin
        overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    set_ovr = 1'b0;
    case (state_q)
      EMPTY: begin
        if (done) state_d = FULL;
      end
      FULL: begin
        if (done) begin
          state_d = FULL;
          set_ovr = ~avg_ready;
        end else if (avg_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign avg_valid = (state_q == FULL);

endmodule

// File: tb/tb_sample_avg.sv
// Directed self-checking bench for sample_avg at AVG_LOG2=2 and AVG_LOG2=0.
module tb_sample_avg;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       trig_in;
  logic [7:0] code_in;
  logic       avg_ready;

  logic [7:0] avg_out2, avg_out0;
  logic       avg_valid2, avg_valid0;
  logic       overrun2, overrun0;
  logic [2:0] sample_cnt2;
  logic [0:0] sample_cnt0;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sample_avg #(.AVG_LOG2(2)) dut2 (
    .clk        (clk),
    .n_rst      (n_rst),
    .trig_in    (trig_in),
    .code_in    (code_in),
    .avg_ready  (avg_ready),
    .avg_out    (avg_out2),
    .avg_valid  (avg_valid2),
    .overrun    (overrun2),
    .sample_cnt (sample_cnt2)
  );

  sample_avg #(.AVG_LOG2(0)) dut0 (
    .clk        (clk),
    .n_rst      (n_rst),
    .trig_in    (trig_in),
    .code_in    (code_in),
    .avg_ready  (avg_ready),
    .avg_out    (avg_out0),
    .avg_valid  (avg_valid0),
    .overrun    (overrun0),
    .sample_cnt (sample_cnt0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One trigger pulse of 'hi' cycles; returns once the sample has been absorbed.
  task automatic sample(input logic [7:0] c, input int hi);
    code_in = c;
    trig_in = 1'b1;
    repeat (hi) tick();
    trig_in = 1'b0;
    tick();
    tick();
  endtask

  logic [7:0] codes0 [3] = '{8'd0, 8'd128, 8'd255};

  initial begin
    n_rst = 1'b1; trig_in = 1'b0; code_in = 8'd0; avg_ready = 1'b1;
    repeat (2) tick();
    n_rst = 1'b0;
    check("rst_out",   avg_out2,    0);
    check("rst_valid", avg_valid2,  0);
    check("rst_ovr",   overrun2,    0);
    check("rst_cnt",   sample_cnt2, 0);
    tick();

    // Average of 10,20,30,41 = 101>>2 = 25, valid for one cycle
    sample(8'd10, 1); check("avg_cnt1", sample_cnt2, 1);
    sample(8'd20, 1); check("avg_cnt2", sample_cnt2, 2);
    sample(8'd30, 1); check("avg_cnt3", sample_cnt2, 3);
    code_in = 8'd41; trig_in = 1'b1; tick();
    trig_in = 1'b0; tick();
    check("avg_lat1_valid", avg_valid2, 0);
    tick();
    check("avg_valid", avg_valid2, 1);
    check("avg_out",   avg_out2,    25);
    check("avg_cnt0",  sample_cnt2, 0);
    tick();
    check("avg_consumed", avg_valid2, 0);

    // Long trigger pulse: exactly one sample
    code_in = 8'd77; trig_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("long_hi_cnt", sample_cnt2, 0);
    end
    trig_in = 1'b0; tick();
    check("long_fall_cnt", sample_cnt2, 0);
    tick();
    check("long_one", sample_cnt2, 1);
    repeat (3) tick();
    check("long_hold", sample_cnt2, 1);

    // Mid-window reset, with a trigger fall spanning reset release
    sample(8'd200, 1); sample(8'd200, 1);
    check("pre_rst_cnt", sample_cnt2, 3);
    trig_in = 1'b1; tick();
    n_rst = 1'b1; tick();
    n_rst = 1'b0; trig_in = 1'b0;
    check("mid_rst_cnt",   sample_cnt2, 0);
    check("mid_rst_out",   avg_out2,    0);
    check("mid_rst_valid", avg_valid2,  0);
    tick(); tick();
    check("span_no_sample", sample_cnt2, 0);
    repeat (4) sample(8'd8, 1);
    check("post_rst_out",   avg_out2,   8);
    check("post_rst_valid", avg_valid2, 1);
    tick();
    check("post_rst_taken", avg_valid2, 0);

    // Overrun: two windows of 255 with no consumer
    avg_ready = 1'b0;
    repeat (4) sample(8'd255, 1);
    check("ovr_a_out",   avg_out2,   255);
    check("ovr_a_valid", avg_valid2, 1);
    check("ovr_a_flag",  overrun2,   0);
    repeat (4) sample(8'd255, 1);
    check("ovr_b_out",   avg_out2,   255);
    check("ovr_b_valid", avg_valid2, 1);
    check("ovr_b_flag",  overrun2,   1);
    avg_ready = 1'b1; tick();
    check("ovr_drain_valid", avg_valid2, 0);
    check("ovr_sticky",      overrun2,   1);
    n_rst = 1'b1; tick(); n_rst = 1'b0;
    check("ovr_rst", overrun2, 0);

    // Result B completes on the handshake cycle of result A
    avg_ready = 1'b0;
    repeat (4) sample(8'd4, 1);
    check("hs_a_out",   avg_out2,   4);
    check("hs_a_valid", avg_valid2, 1);
    repeat (3) sample(8'd100, 1);
    check("hs_a_hold", avg_out2,    4);
    check("hs_cnt3",   sample_cnt2, 3);
    code_in = 8'd100; trig_in = 1'b1; tick();
    trig_in = 1'b0; tick();
    avg_ready = 1'b1; tick();
    check("hs_b_out",   avg_out2,   100);
    check("hs_b_valid", avg_valid2, 1);
    check("hs_b_ovr",   overrun2,   0);
    tick();
    check("hs_b_taken", avg_valid2, 0);

    // AVG_LOG2=0: every sample is a result
    n_rst = 1'b1; tick(); n_rst = 1'b0;
    avg_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      code_in = codes0[i]; trig_in = 1'b1; tick();
      trig_in = 1'b0; tick();
      check("l0_lat1_valid", avg_valid0, 0);
      tick();
      check("l0_valid", avg_valid0,  1);
      check("l0_out",   avg_out0,    32'(codes0[i]));
      check("l0_cnt",   sample_cnt0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sample_avg.md
SAMPLE_AVG -- requirements
Module: sample_avg

Interface
REQ-001 The block SHALL have parameter AVG_LOG2, default 4, giving log2 of the samples per average (legal range 0..6).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port n_rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port trig_in, input, 1 bit: the same comparator trigger that drives the upstream counter-capture stage.
REQ-005 The block SHALL have port code_in, input, 8 bits: the upstream captured code (counter_out).
REQ-006 The block SHALL have port avg_ready, input, 1 bit: the downstream consumer accepts the result.
REQ-007 The block SHALL have port avg_out, output, 8 bits: the averaged code.
REQ-008 The block SHALL have port avg_valid, output, 1 bit: avg_out holds an unconsumed result.
REQ-009 The block SHALL have port overrun, output, 1 bit: sticky flag meaning a result was overwritten before it was consumed.
REQ-010 The block SHALL have port sample_cnt, output, AVG_LOG2+1 bits: samples accumulated so far in the current window.

Function
REQ-011 The block SHALL register trig_in once (trig_q) and SHALL detect a falling edge when trig_q=1 and trig_in=0.
REQ-012 On the cycle after a detected falling edge, the block SHALL take one sample equal to code_in; upstream then holds the code captured on the last trigger-high cycle.
REQ-013 A trigger pulse of any length SHALL produce exactly one sample; a trigger that is still high SHALL produce no sample.
REQ-014 Each sample SHALL be added to an unsigned accumulator of 8+AVG_LOG2 bits, which by construction cannot overflow.
REQ-015 When the sample count reaches 2^AVG_LOG2, on that same cycle:
- avg_out SHALL load acc[7+AVG_LOG2:AVG_LOG2] (truncating, no rounding);
- the accumulator and the counter SHALL clear;
- avg_valid SHALL go to 1 on the next cycle.
REQ-016 The result latency SHALL be 2 cycles from the final trig_in falling edge to avg_valid=1.
REQ-017 The output SHALL follow a valid/ready handshake: avg_valid stays 1 and avg_out stays stable until a cycle with avg_valid=1 and avg_ready=1, after which avg_valid is 0 on the next cycle.
REQ-018 Accumulation SHALL continue while a result is pending; the accumulator and the output register are independent stages.
REQ-019 If a new result completes while avg_valid=1 and avg_ready=0:
- avg_out SHALL take the new value;
- avg_valid SHALL stay 1;
- overrun SHALL set to 1 and remain 1 until reset.
REQ-020 If a new result completes in the same cycle as a handshake, the old result SHALL count as consumed, avg_out SHALL load the new value, avg_valid SHALL stay 1, and overrun SHALL not set.
REQ-021 The output state machine SHALL have two states:
- EMPTY goes to FULL when a result completes;
- FULL goes to EMPTY on a handshake with no new result;
- FULL stays FULL on a new result, whether or not a handshake occurs.
REQ-022 avg_valid SHALL be 1 exactly when the state is FULL.
REQ-023 With AVG_LOG2=0, every sample SHALL produce a result equal to code_in.
REQ-024 sample_cnt SHALL report the number of samples in the current window, from 0 to 2^AVG_LOG2-1.

Reset
REQ-025 When n_rst=1 at a clock edge, the block SHALL clear acc, sample_cnt, avg_out, avg_valid, overrun and trig_q to 0 and SHALL set the state to EMPTY.
REQ-026 A reset in the middle of a window SHALL discard the partial sum.
REQ-027 A trigger falling edge that spans the reset deassertion SHALL not be sampled, because trig_q is 0 out of reset.
REQ-028 The first sample after reset SHALL require a full trig_in high-then-low sequence that begins after reset is released.

Structure
REQ-029 The shared package gr02_pkg SHALL hold CODE_W=8, the output-state enum (EMPTY, FULL) and the AVG_LOG2 maximum of 6.
REQ-030 The block SHALL contain one sub-module, edge_det, a registered falling-edge detector with clk and n_rst ports; all other logic SHALL be in sample_avg.

Verification
REQ-031 With AVG_LOG2=2, codes 10, 20, 30, 41 each followed by a trig_in fall, and avg_ready=1, the bench SHALL observe avg_out=25 (101>>2) and avg_valid high 2 cycles after the 4th fall, for one cycle.
REQ-032 With AVG_LOG2=2, avg_ready=0 and 8 samples all of value 255, the bench SHALL observe avg_out=255, avg_valid=1 and overrun=1 after the 8th sample.
REQ-033 With one trig_in pulse held high for 5 cycles and code_in=77, the bench SHALL observe exactly one sample (sample_cnt 0 to 1) and no extra counts while trig_in is high.
REQ-034 With AVG_LOG2=2, 3 samples taken, then n_rst pulsed for 1 cycle, then 4 samples of value 8, the bench SHALL observe avg_out=8 (no residue from before reset) and sample_cnt=0 right after reset.
REQ-035 With AVG_LOG2=2, result A pending and the next result B completing in the same cycle as the handshake, the bench SHALL observe avg_out=B, avg_valid=1 and overrun=0.
REQ-036 With AVG_LOG2=0, codes 0, 128 and 255, the bench SHALL observe avg_out of 0, 128 and 255, each valid 2 cycles after its trigger fall.
